sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one asynchronous SRAM port (20-bit word address, 32-bit data, active-low strobes) between the instruction-fetch requester (IF) and the load/store requester (MEM).
- Arbitrates per transaction and sequences the SRAM read and write timing with a registered FSM.
- Returns data to the winner through a REQ/ACK handshake.
- Sits between the fetch/memory stages and the SRAM pin-level controller.

Parameters:
- READ_WAIT, 1, SRAM cycles with CE_N/OE_N asserted before read data is captured (>=1).
- WRITE_PULSE, 2, cycles WE_N is held low (>=1).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- IF_REQ  input  1  fetch request; held until IF_ACK.
- IF_ADDR  input  20  fetch word address.
- IF_ACK  output  1  one-cycle completion pulse for IF.
- IF_RDATA  output  32  fetch data; valid while IF_ACK=1.
- MEM_REQ  input  1  load/store request; held until MEM_ACK.
- MEM_WE  input  1  1=write, 0=read.
- MEM_BE  input  4  byte enables, active high.
- MEM_ADDR  input  20  data word address.
- MEM_WDATA  input  32  store data.
- MEM_ACK  output  1  one-cycle completion pulse for MEM.
- MEM_RDATA  output  32  load data; valid while MEM_ACK=1.
- SRAM_CE_N  output  1  chip enable, active low.
- SRAM_OE_N  output  1  output enable, active low.
- SRAM_WE_N  output  1  write enable, active low.
- SRAM_BE_N  output  4  byte enables, active low.
- SRAM_ADDR  output  20  SRAM address.
- SRAM_WDATA  output  32  write data.
- SRAM_WDATA_OE  output  1  1 = drive the data bus (write phases only).
- SRAM_RDATA  input  32  SRAM read data.

Behaviour:
- All outputs are registered (FSM-state decoded from flops).
- Reset values:
  - CE_N=1, OE_N=1, WE_N=1, BE_N=4'b1111.
  - SRAM_ADDR=0, SRAM_WDATA=0, WDATA_OE=0.
  - Both ACKs=0; IF_RDATA=0, MEM_RDATA=0.
  - FSM=IDLE; rr pointer=IF.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - Samples requests. Fixed priority: MEM wins over IF.
  - On grant, latch the owner, address, WE, BE and WDATA. Inputs are ignored afterwards until DONE.
  - No request: stay IDLE with all strobes inactive.
- Read (grant in cycle t):
  - RD for READ_WAIT cycles (t+1..t+READ_WAIT).
  - During RD: CE_N=0, OE_N=0, BE_N=0000 (MEM_BE ignored for reads).
  - SRAM_RDATA is captured at the end of the last RD cycle.
  - DONE at t+READ_WAIT+1: owner's ACK=1, RDATA holds the captured word, strobes inactive.
- Write (grant in cycle t):
  - WR_SETUP, 1 cycle: CE_N=0, WE_N=1, WDATA_OE=1.
  - WR_PULSE, WRITE_PULSE cycles: WE_N=0.
  - WR_HOLD, 1 cycle: WE_N=1, WDATA_OE=1, address and data stable.
  - DONE at t+WRITE_PULSE+3.
  - For all write states: OE_N=1 and BE_N=~latched BE.
- Write with MEM_BE=0000: no SRAM activity; IDLE goes directly to DONE, ACK at t+1.
- DONE:
  - Always returns to IDLE; there is no back-to-back grant from DONE.
  - Minimum of 1 IDLE cycle between transactions.
- Handshake:
  - The requester drops REQ in the cycle after ACK.
  - REQ still high in the IDLE cycle after DONE is a new request.
  - REQ dropped mid-transaction: the transaction completes and ACK still pulses.
  - The non-owner's ACK stays 0 and its RDATA holds its last value.
- Simultaneous IF_REQ and MEM_REQ: MEM granted. IF waits with REQ held and is granted in the next IDLE that has no MEM_REQ.
- RST mid-transaction:
  - At the next edge all outputs return to their reset values; the FSM goes to IDLE.
  - No ACK is issued for the aborted transaction.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On simultaneous requests the grant goes to the requester that did not win the last grant.
  - The rr pointer updates on every grant.
  - Reset pointer = IF has priority, so the first conflict grants IF.
- Undefined: fixed MEM priority as above; no pointer flop.

Test Plan:
- Single fetch, READ_WAIT=1: IF_REQ=1, IF_ADDR=20'h00010, SRAM_RDATA=32'h3C011234 -> CE_N/OE_N low for exactly 1 cycle with SRAM_ADDR=20'h00010; IF_ACK pulses at t+2 with IF_RDATA=32'h3C011234; MEM_ACK stays 0.
- Byte store: MEM_REQ=1, MEM_WE=1, MEM_BE=4'b0010, MEM_ADDR=20'h80000, MEM_WDATA=32'h0000AB00 -> WE_N low exactly 2 cycles, bracketed by 1 setup and 1 hold cycle; BE_N=4'b1101 throughout; MEM_ACK at t+5.
- Conflict: IF_REQ and MEM_REQ (read, 20'h00100) both raised in the same cycle -> MEM completes first. IF is granted in the IDLE cycle after the MEM DONE and IF_ACK follows 2 cycles later. With SRAM_ARB_RR_EN: IF first, then MEM.
- Empty store: MEM_WE=1, MEM_BE=4'b0000 -> CE_N stays 1 and MEM_ACK at t+1.
- Reset during WR_PULSE: assert RST for 1 cycle -> next edge gives WE_N=1, CE_N=1, WDATA_OE=0; no MEM_ACK; a fresh IF read then completes normally.
- Back-to-back fetches with IF_REQ held high: consecutive IF_ACK pulses are 3 cycles apart (READ_WAIT=1), with one IDLE cycle with all strobes high between them.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Arbitrates one asynchronous SRAM port between instruction fetch (IF) and load/store (MEM).
// Optional macro SRAM_ARB_RR_EN selects round-robin arbitration instead of fixed MEM priority.
module sram_port_arbiter #(
  parameter int READ_WAIT   = 1,
  parameter int WRITE_PULSE = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_REQ,
  input  logic [19:0] IF_ADDR,
  output logic        IF_ACK,
  output logic [31:0] IF_RDATA,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [3:0]  MEM_BE,
  input  logic [19:0] MEM_ADDR,
  input  logic [31:0] MEM_WDATA,
  output logic        MEM_ACK,
  output logic [31:0] MEM_RDATA,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic [3:0]  SRAM_BE_N,
  output logic [19:0] SRAM_ADDR,
  output logic [31:0] SRAM_WDATA,
  output logic        SRAM_WDATA_OE,
  input  logic [31:0] SRAM_RDATA
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

  localparam logic [7:0] RD_LAST = 8'(READ_WAIT - 1);
  localparam logic [7:0] WP_LAST = 8'(WRITE_PULSE - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        own_mem_q, own_mem_d;
  logic [3:0]  be_q, be_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic [3:0]  be_n_q, be_n_d;
  logic        wdata_oe_q, wdata_oe_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        grant_mem, grant_if;

`ifdef SRAM_ARB_RR_EN
  // rr_q=1 means MEM holds priority on the next conflict
  logic rr_q, rr_d;
  assign grant_mem = MEM_REQ && (!IF_REQ || rr_q);
`else
  assign grant_mem = MEM_REQ;
`endif
  assign grant_if = IF_REQ && !grant_mem;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_mem_d   = own_mem_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    be_n_d      = 4'hF;
    wdata_oe_d  = 1'b0;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
`ifdef SRAM_ARB_RR_EN
    rr_d        = rr_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_mem || grant_if) begin
          own_mem_d = grant_mem;
          addr_d    = grant_mem ? MEM_ADDR : IF_ADDR;
          cnt_d     = 8'd0;
`ifdef SRAM_ARB_RR_EN
          rr_d      = grant_if;
`endif
          if (grant_mem && MEM_WE) begin
            be_d    = MEM_BE;
            wdata_d = MEM_WDATA;
            // An all-zero byte mask has nothing to write: skip the SRAM cycle
            state_d = (MEM_BE == 4'b0000) ? DONE : WR_SETUP;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          if (own_mem_q) mem_rdata_d = SRAM_RDATA;
          else           if_rdata_d  = SRAM_RDATA;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WR_SETUP: begin
        cnt_d   = 8'd0;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q == WP_LAST) state_d = WR_HOLD;
        else                  cnt_d   = cnt_q + 8'd1;
      end
      WR_HOLD: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so they are registered with it
    case (state_d)
      RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = 4'b0000;
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_d     = 1'b0;
        be_n_d     = ~be_d;
        wdata_oe_d = 1'b1;
      end
      WR_PULSE: begin
        ce_n_d     = 1'b0;
        we_n_d     = 1'b0;
        be_n_d     = ~be_d;
        wdata_oe_d = 1'b1;
      end
      DONE: begin
        if_ack_d  = !own_mem_d;
        mem_ack_d = own_mem_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      own_mem_q   <= 1'b0;
      be_q        <= 4'h0;
      addr_q      <= 20'h0;
      wdata_q     <= 32'h0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 4'hF;
      wdata_oe_q  <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
`ifdef SRAM_ARB_RR_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_mem_q   <= own_mem_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
      wdata_oe_q  <= wdata_oe_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef SRAM_ARB_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign IF_ACK        = if_ack_q;
  assign IF_RDATA      = if_rdata_q;
  assign MEM_ACK       = mem_ack_q;
  assign MEM_RDATA     = mem_rdata_q;
  assign SRAM_CE_N     = ce_n_q;
  assign SRAM_OE_N     = oe_n_q;
  assign SRAM_WE_N     = we_n_q;
  assign SRAM_BE_N     = be_n_q;
  assign SRAM_ADDR     = addr_q;
  assign SRAM_WDATA    = wdata_q;
  assign SRAM_WDATA_OE = wdata_oe_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (READ_WAIT=1, WRITE_PULSE=2) with hand-computed expectations.
module tb_sram_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IF_REQ;
  logic [19:0] IF_ADDR;
  logic        IF_ACK;
  logic [31:0] IF_RDATA;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [3:0]  MEM_BE;
  logic [19:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic [3:0]  SRAM_BE_N;
  logic [19:0] SRAM_ADDR;
  logic [31:0] SRAM_WDATA;
  logic        SRAM_WDATA_OE;
  logic [31:0] SRAM_RDATA;

  int n_vec = 0;
  int n_err = 0;
  bit rr_mode;

  sram_port_arbiter #(.READ_WAIT(1), .WRITE_PULSE(2)) dut (
    .CLK(CLK), .RST(RST),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK), .IF_RDATA(IF_RDATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_BE_N(SRAM_BE_N), .SRAM_ADDR(SRAM_ADDR), .SRAM_WDATA(SRAM_WDATA),
    .SRAM_WDATA_OE(SRAM_WDATA_OE), .SRAM_RDATA(SRAM_RDATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and outputs are both handled 1 ns after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle_strobes(input string tag);
    chk({tag, ".ce_n"}, 32'(SRAM_CE_N), 32'd1);
    chk({tag, ".oe_n"}, 32'(SRAM_OE_N), 32'd1);
    chk({tag, ".we_n"}, 32'(SRAM_WE_N), 32'd1);
    chk({tag, ".wdoe"}, 32'(SRAM_WDATA_OE), 32'd0);
  endtask

  initial begin
`ifdef SRAM_ARB_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    RST = 1'b1; IF_REQ = 0; IF_ADDR = 0; MEM_REQ = 0; MEM_WE = 0; MEM_BE = 0;
    MEM_ADDR = 0; MEM_WDATA = 0; SRAM_RDATA = 0;
    tick(); tick();
    chk_idle_strobes("rst");
    chk("rst.be_n", 32'(SRAM_BE_N), 32'hF);
    chk("rst.addr", 32'(SRAM_ADDR), 32'h0);
    chk("rst.wdata", SRAM_WDATA, 32'h0);
    chk("rst.acks", {30'd0, IF_ACK, MEM_ACK}, 32'd0);
    chk("rst.rdata", IF_RDATA | MEM_RDATA, 32'h0);
    RST = 1'b0;
    tick();

    // Single fetch
    IF_REQ = 1; IF_ADDR = 20'h00010; SRAM_RDATA = 32'h3C011234;
    tick();
    chk("f1.ce_n", 32'(SRAM_CE_N), 32'd0);
    chk("f1.oe_n", 32'(SRAM_OE_N), 32'd0);
    chk("f1.be_n", 32'(SRAM_BE_N), 32'h0);
    chk("f1.addr", 32'(SRAM_ADDR), 32'h00010);
    chk("f1.ack_early", 32'(IF_ACK), 32'd0);
    tick();
    chk("f1.ack", 32'(IF_ACK), 32'd1);
    chk("f1.rdata", IF_RDATA, 32'h3C011234);
    chk("f1.mem_ack", 32'(MEM_ACK), 32'd0);
    chk_idle_strobes("f1.done");
    IF_REQ = 0;
    tick();
    chk("f1.ack_drop", 32'(IF_ACK), 32'd0);
    chk_idle_strobes("f1.idle");

    // Byte store
    MEM_REQ = 1; MEM_WE = 1; MEM_BE = 4'b0010; MEM_ADDR = 20'h80000; MEM_WDATA = 32'h0000AB00;
    tick();
    chk("st.setup.ce_n", 32'(SRAM_CE_N), 32'd0);
    chk("st.setup.we_n", 32'(SRAM_WE_N), 32'd1);
    chk("st.setup.wdoe", 32'(SRAM_WDATA_OE), 32'd1);
    chk("st.setup.be_n", 32'(SRAM_BE_N), 32'hD);
    chk("st.addr", 32'(SRAM_ADDR), 32'h80000);
    chk("st.wdata", SRAM_WDATA, 32'h0000AB00);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st.pulse.we_n", 32'(SRAM_WE_N), 32'd0);
      chk("st.pulse.oe_n", 32'(SRAM_OE_N), 32'd1);
      chk("st.pulse.be_n", 32'(SRAM_BE_N), 32'hD);
    end
    tick();
    chk("st.hold.we_n", 32'(SRAM_WE_N), 32'd1);
    chk("st.hold.wdoe", 32'(SRAM_WDATA_OE), 32'd1);
    chk("st.hold.ce_n", 32'(SRAM_CE_N), 32'd0);
    chk("st.hold.ack", 32'(MEM_ACK), 32'd0);
    tick();
    chk("st.ack", 32'(MEM_ACK), 32'd1);
    chk("st.if_ack", 32'(IF_ACK), 32'd0);
    chk_idle_strobes("st.done");
    MEM_REQ = 0; MEM_WE = 0;
    tick();
    chk("st.ack_drop", 32'(MEM_ACK), 32'd0);

    // Conflict: MEM read and IF read raised together
    IF_REQ = 1; IF_ADDR = 20'h00200;
    MEM_REQ = 1; MEM_WE = 0; MEM_BE = 4'hF; MEM_ADDR = 20'h00100;
    SRAM_RDATA = 32'hCAFEF00D;
    tick();
    chk("cf1.addr", 32'(SRAM_ADDR), rr_mode ? 32'h00200 : 32'h00100);
    chk("cf1.oe_n", 32'(SRAM_OE_N), 32'd0);
    tick();
    chk("cf1.if_ack", 32'(IF_ACK), rr_mode ? 32'd1 : 32'd0);
    chk("cf1.mem_ack", 32'(MEM_ACK), rr_mode ? 32'd0 : 32'd1);
    chk("cf1.if_rdata", IF_RDATA, rr_mode ? 32'hCAFEF00D : 32'h3C011234);
    chk("cf1.mem_rdata", MEM_RDATA, rr_mode ? 32'h0 : 32'hCAFEF00D);
    if (rr_mode) IF_REQ = 0;
    else         MEM_REQ = 0;
    SRAM_RDATA = 32'h12345678;
    tick();
    chk("cf.gap.acks", {30'd0, IF_ACK, MEM_ACK}, 32'd0);
    chk_idle_strobes("cf.gap");
    tick();
    chk("cf2.addr", 32'(SRAM_ADDR), rr_mode ? 32'h00100 : 32'h00200);
    tick();
    chk("cf2.if_ack", 32'(IF_ACK), rr_mode ? 32'd0 : 32'd1);
    chk("cf2.mem_ack", 32'(MEM_ACK), rr_mode ? 32'd1 : 32'd0);
    chk("cf2.if_rdata", IF_RDATA, rr_mode ? 32'hCAFEF00D : 32'h12345678);
    chk("cf2.mem_rdata", MEM_RDATA, rr_mode ? 32'h12345678 : 32'hCAFEF00D);
    IF_REQ = 0; MEM_REQ = 0;
    tick();

    // Empty store
    MEM_REQ = 1; MEM_WE = 1; MEM_BE = 4'b0000; MEM_ADDR = 20'h00123; MEM_WDATA = 32'h55AA55AA;
    tick();
    chk("es.ack", 32'(MEM_ACK), 32'd1);
    chk_idle_strobes("es");
    MEM_REQ = 0; MEM_WE = 0;
    tick();
    chk("es.ack_drop", 32'(MEM_ACK), 32'd0);
    chk("es.ce_n", 32'(SRAM_CE_N), 32'd1);

    // Reset during WR_PULSE
    MEM_REQ = 1; MEM_WE = 1; MEM_BE = 4'hF; MEM_ADDR = 20'h00055; MEM_WDATA = 32'h11223344;
    tick();
    tick();
    chk("rw.pulse.we_n", 32'(SRAM_WE_N), 32'd0);
    RST = 1; MEM_REQ = 0; MEM_WE = 0;
    tick();
    chk_idle_strobes("rw.rst");
    chk("rw.rst.addr", 32'(SRAM_ADDR), 32'h0);
    chk("rw.rst.rdata", IF_RDATA | MEM_RDATA, 32'h0);
    RST = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rw.no_ack", {30'd0, IF_ACK, MEM_ACK}, 32'd0);
    end
    IF_REQ = 1; IF_ADDR = 20'h00077; SRAM_RDATA = 32'h0BADBEEF;
    tick();
    chk("rw.f.addr", 32'(SRAM_ADDR), 32'h00077);
    tick();
    chk("rw.f.ack", 32'(IF_ACK), 32'd1);
    chk("rw.f.rdata", IF_RDATA, 32'h0BADBEEF);
    IF_REQ = 0;
    tick();

    // Back-to-back fetches with IF_REQ held
    IF_REQ = 1; IF_ADDR = 20'h00300; SRAM_RDATA = 32'h13572468;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("bb%0d.ack", k), 32'(IF_ACK), (k % 3 == 2) ? 32'd1 : 32'd0);
      chk($sformatf("bb%0d.ce_n", k), 32'(SRAM_CE_N), (k % 3 == 1) ? 32'd0 : 32'd1);
      chk($sformatf("bb%0d.oe_n", k), 32'(SRAM_OE_N), (k % 3 == 1) ? 32'd0 : 32'd1);
    end
    chk("bb.rdata", IF_RDATA, 32'h13572468);
    IF_REQ = 0;
    tick();
    tick();
    chk_idle_strobes("bb.end");
    chk("bb.end.ack", 32'(IF_ACK), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
